// File: rtl/block_mm_sched.sv
// block_mm_sched: walks every (i,j) of a SIZE x SIZE complex product C = A*B,
// one element per pass through a shared complex_matrix_mul engine.
// Ports: clk_i/rst_i (sync, active-high), start_i, busy_o, done_o;
//   read:  rd_req_o, a_rd_addr_o, b_rd_addr_o, rd_valid_i, a_row_i, b_col_i;
//   engine: mul_in_valid_o/ready_i, mul_operands_o, mul_out_valid_i/ready_o,
//           mul_result_i;
//   write: wr_valid_o, wr_ready_i, wr_row_o, wr_col_o, wr_data_o.
// Option BLOCK_MM_SCHED_ACC_EN adds an adder pass computing C_old +/- A*B
//   (acc_i, sub_i, c_elem_i, add_* ports and the ADD states).
module block_mm_sched #(
  parameter int SIZE  = 4,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(SIZE)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      rd_req_o,
  output logic [AW-1:0]             a_rd_addr_o,
  output logic [AW-1:0]             b_rd_addr_o,
  input  logic                      rd_valid_i,
  input  logic [SIZE*2*WIDTH-1:0]   a_row_i,
  input  logic [SIZE*2*WIDTH-1:0]   b_col_i,
  output logic                      mul_in_valid_o,
  input  logic                      mul_in_ready_i,
  output logic [SIZE*4*WIDTH-1:0]   mul_operands_o,
  input  logic                      mul_out_valid_i,
  output logic                      mul_out_ready_o,
  input  logic [2*WIDTH-1:0]        mul_result_i,
  output logic                      wr_valid_o,
  input  logic                      wr_ready_i,
  output logic [AW-1:0]             wr_row_o,
  output logic [AW-1:0]             wr_col_o,
  output logic [2*WIDTH-1:0]        wr_data_o
`ifdef BLOCK_MM_SCHED_ACC_EN
  ,
  input  logic                      acc_i,
  input  logic                      sub_i,
  input  logic [2*WIDTH-1:0]        c_elem_i,
  output logic                      add_valid_o,
  input  logic                      add_ready_i,
  output logic [4*WIDTH-1:0]        add_operands_o,
  output logic                      add_sub_o,
  input  logic                      add_out_valid_i,
  output logic                      add_out_ready_o,
  input  logic [2*WIDTH-1:0]        add_result_i
`endif
);

  localparam int RW = SIZE * 2 * WIDTH;
  localparam int EW = 2 * WIDTH;
  localparam logic [AW-1:0] LAST = AW'(SIZE - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_READ,
    S_WAIT_RD,
    S_ISSUE,
    S_WAIT_MUL,
    S_WRITE,
    S_DONE
`ifdef BLOCK_MM_SCHED_ACC_EN
    ,
    S_ADD,
    S_ADD_WAIT
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] i_q, i_d, j_q, j_d;
  logic [RW-1:0] a_q, a_d, b_q, b_d;
  logic [EW-1:0] res_q, res_d;
`ifdef BLOCK_MM_SCHED_ACC_EN
  logic [EW-1:0] c_q, c_d;
  logic          acc_q, acc_d, sub_q, sub_d;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
`ifdef BLOCK_MM_SCHED_ACC_EN
      c_q     <= '0;
      acc_q   <= 1'b0;
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
`ifdef BLOCK_MM_SCHED_ACC_EN
      c_q     <= c_d;
      acc_q   <= acc_d;
      sub_q   <= sub_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
`ifdef BLOCK_MM_SCHED_ACC_EN
    c_d     = c_q;
    acc_d   = acc_q;
    sub_d   = sub_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_READ;
          i_d     = '0;
          j_d     = '0;
`ifdef BLOCK_MM_SCHED_ACC_EN
          acc_d   = acc_i;
          sub_d   = sub_i;
`endif
        end
      end
      S_READ: state_d = S_WAIT_RD;
      S_WAIT_RD: begin
        if (rd_valid_i) begin
          a_d     = a_row_i;
          b_d     = b_col_i;
`ifdef BLOCK_MM_SCHED_ACC_EN
          c_d     = c_elem_i;
`endif
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mul_in_ready_i) state_d = S_WAIT_MUL;
      end
      S_WAIT_MUL: begin
        if (mul_out_valid_i) begin
          res_d = mul_result_i;
`ifdef BLOCK_MM_SCHED_ACC_EN
          state_d = acc_q ? S_ADD : S_WRITE;
`else
          state_d = S_WRITE;
`endif
        end
      end
`ifdef BLOCK_MM_SCHED_ACC_EN
      S_ADD: begin
        if (add_ready_i) state_d = S_ADD_WAIT;
      end
      S_ADD_WAIT: begin
        if (add_out_valid_i) begin
          res_d   = add_result_i;
          state_d = S_WRITE;
        end
      end
`endif
      S_WRITE: begin
        // the (SIZE-1,SIZE-1) write ends the pass; counters never wrap
        if (wr_ready_i) begin
          if (j_q != LAST) begin
            j_d     = j_q + 1'b1;
            state_d = S_READ;
          end else if (i_q != LAST) begin
            j_d     = '0;
            i_d     = i_q + 1'b1;
            state_d = S_READ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o          = (state_q != S_IDLE);
    done_o          = (state_q == S_DONE);
    rd_req_o        = (state_q == S_READ);
    mul_in_valid_o  = (state_q == S_ISSUE);
    mul_out_ready_o = (state_q == S_WAIT_MUL);
    wr_valid_o      = (state_q == S_WRITE);
`ifdef BLOCK_MM_SCHED_ACC_EN
    add_valid_o     = (state_q == S_ADD);
    add_out_ready_o = (state_q == S_ADD_WAIT);
    add_sub_o       = sub_q & (state_q == S_ADD);
`endif
  end

  // engine slot k: {b_im, b_re, a_im, a_re} from element k of row/column
  always_comb begin
    mul_operands_o = '0;
    for (int k = 0; k < SIZE; k++) begin
      mul_operands_o[(4*k+0)*WIDTH +: WIDTH] = a_q[(2*k+0)*WIDTH +: WIDTH];
      mul_operands_o[(4*k+1)*WIDTH +: WIDTH] = a_q[(2*k+1)*WIDTH +: WIDTH];
      mul_operands_o[(4*k+2)*WIDTH +: WIDTH] = b_q[(2*k+0)*WIDTH +: WIDTH];
      mul_operands_o[(4*k+3)*WIDTH +: WIDTH] = b_q[(2*k+1)*WIDTH +: WIDTH];
    end
  end

  assign a_rd_addr_o = i_q;
  assign b_rd_addr_o = j_q;
  assign wr_row_o    = i_q;
  assign wr_col_o    = j_q;
  assign wr_data_o   = res_q;
`ifdef BLOCK_MM_SCHED_ACC_EN
  assign add_operands_o = {res_q, c_q};
`endif

endmodule

// File: doc/block_mm_sched.md
Name: block_mm_sched

Overview:
- Sequencer that computes one SIZE×SIZE complex matrix product C = A·B on the shared complex_matrix_mul engine, one output element per pass.
- Per element (i,j): reads row i of A and column j of B from the external row store, packs the engine operands, drives the engine handshake and writes the result element back.
- The block-LU flow uses it for the Linv·A01, A10·Uinv and Schur-update steps, in place of bench-driven loops.

Parameters:
- SIZE, 4, matrix dimension; elements visited i=0..SIZE-1 outer, j=0..SIZE-1 inner.
- WIDTH, 64, bits per real or imaginary part (IEEE double).
- AW, $clog2(SIZE), row/column address width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  begin a product; sampled only in IDLE.
- busy_o  out  1  high from the accepted start through the DONE cycle.
- done_o  out  1  one-cycle pulse after the last element is written.
- rd_req_o  out  1  read request, one cycle per element.
- a_rd_addr_o  out  AW  row i of A.
- b_rd_addr_o  out  AW  column j of B (store holds B column-addressable).
- rd_valid_i  in  1  read data valid; any cycle after rd_req_o.
- a_row_i  in  SIZE*2*WIDTH  element k = {im,re} at k*2*WIDTH.
- b_col_i  in  SIZE*2*WIDTH  same packing.
- mul_in_valid_o  out  1  operands valid.
- mul_in_ready_i  in  1  engine accepts.
- mul_operands_o  out  SIZE*4*WIDTH  slot k*4+0 a_re, +1 a_im, +2 b_re, +3 b_im.
- mul_out_valid_i  in  1  engine result valid.
- mul_out_ready_o  out  1  result accept.
- mul_result_i  in  2*WIDTH  {im,re}.
- wr_valid_o  out  1  write element.
- wr_ready_i  in  1  store accepts.
- wr_row_o, wr_col_o  out  AW  element (i,j).
- wr_data_o  out  2*WIDTH  {im,re}.

Behaviour:
- Reset: all outputs 0, state IDLE, i=j=0, data registers cleared. rst_i high in any state aborts the current product: no done_o, and any in-flight engine result is dropped.
- IDLE: busy_o=0. start_i=1 → READ, busy_o=1 next cycle, i=j=0.
- READ: rd_req_o=1 for exactly one cycle with the current addresses → WAIT_RD.
- WAIT_RD: on rd_valid_i, register a_row_i and b_col_i → ISSUE. rd_valid_i in any other state is ignored.
- ISSUE: mul_in_valid_o=1, mul_operands_o driven from the registers and held stable until mul_in_valid_o && mul_in_ready_i → WAIT_MUL.
- WAIT_MUL: mul_out_ready_o=1. On mul_out_valid_i, capture mul_result_i → WRITE (or ADD under the option).
- WRITE: wr_valid_o=1; wr_row_o, wr_col_o and wr_data_o are stable until wr_ready_i. On acceptance:
  - if j<SIZE-1: j++, → READ;
  - else if i<SIZE-1: j=0, i++, → READ;
  - else → DONE.
- DONE: done_o=1 for one cycle, busy_o drops next cycle → IDLE.
- start_i while busy_o=1 is ignored, not queued.
- Minimum element period with zero-wait peers: READ 1 + rd 1 + ISSUE 1 + engine latency + WRITE 1.
- At most one engine transaction is outstanding; the next READ is not issued before the WRITE handshake completes.
- Counters do not wrap: the i=j=SIZE-1 write ends the pass.
- No arithmetic inside the block: data is passed bit-exact; results are whatever the engine returns.

Optional Feature:
- Macro BLOCK_MM_SCHED_ACC_EN.
- When defined:
  - Ports are added: acc_i (in 1, sampled with start_i), sub_i (in 1, sampled with start_i), c_elem_i (in 2*WIDTH, returned with rd_valid_i for element (i,j)), add_valid_o, add_ready_i, add_operands_o (4*WIDTH = {mul_im,mul_re,c_im,c_re}), add_sub_o, add_out_valid_i, add_out_ready_o, add_result_i (2*WIDTH).
  - If acc_i was set: WAIT_MUL → ADD, which drives add_valid_o until add_ready_i, then waits for add_out_valid_i with add_out_ready_o=1 → WRITE with the add result, computing C_old ± A·B.
  - If acc_i was clear: behaviour is identical to the base block.
- When undefined: none of these ports exist, and there is no ADD state.

Test Plan:
- Reset, then start_i with SIZE=4, zero-wait read/engine/write models and A=I, B = element (r,c) = r+j·c → 16 writes in order (0,0)…(3,3), data equals B bit-exact, one done_o, busy_o low after.
- Engine with in_ready held low 7 cycles on element (1,2) → mul_in_valid_o and mul_operands_o stable throughout; no rd_req_o issued until the (1,2) write completes.
- wr_ready_i low 5 cycles on last element → wr_* held, done_o only after acceptance, exactly once.
- start_i pulsed mid-product at element (2,0) → ignored; total writes still 16.
- rst_i asserted in WAIT_MUL at element (0,3) → next cycle all outputs 0, IDLE; late mul_out_valid_i ignored; fresh start_i runs a full 16 elements.
- ACC_EN with acc_i=1, sub_i=1, A=I, B=C=all (2+j1) → every written element is 0+j0; add_sub_o=1 on each add.
